aes: RTL and testbench

AES -- requirements
Module: aes

---
 rtl/aes.sv | 271 +++++++++++++++++++++++++++
 tb/tb_aes.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/aes.sv
// rtl/aes.sv - iterative AES-128/192/256 engine with on-chip key expansion; decryption via AES_DECRYPT_EN
module aes (
    input  logic         clk,
    input  logic         reset,
    input  logic         pt_valid,
    input  logic [127:0] pt_encr,
    output logic         ct_rdy,
    output logic [127:0] ct_encr,
    input  logic         ct_valid,
    input  logic [127:0] ct_decr,
    output logic         pt_rdy,
    output logic [127:0] pt_decr,
    input  logic [1:0]   key_len,
    input  logic [255:0] short_key,
    output logic         key_exp_status,
    output logic         error
);

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xt(x);
        end
        return r;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, p;
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) o[8*n +: 8] = sbox(s[8*n +: 8]);
        return o;
    endfunction

    // byte n of the block sits at [127-8n -: 8]; row n%4, column n/4
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

`ifdef AES_DECRYPT_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) o[8*n +: 8] = inv_sbox(s[8*n +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
                                 gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
                                 gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
                                 gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
        end
        return o;
    endfunction
`endif

    logic [31:0]  w_q [64];
    logic [127:0] state_q, state_d, pend_data_q, pend_data_d;
    logic [127:0] ct_encr_q, ct_encr_d, pt_decr_q, pt_decr_d;
    logic [255:0] win_q, win_d;
    logic [5:0]   exp_idx_q, exp_idx_d;
    logic [3:0]   nk_q, nk_d, nr_q, nr_d, round_q, round_d;
    logic [2:0]   kpos_q, kpos_d;
    logic [7:0]   rcon_q, rcon_d;
    logic busy_q, busy_d, dec_q, dec_d, pend_valid_q, pend_valid_d, pend_dec_q, pend_dec_d;
    logic exp_active_q, exp_active_d, status_q, status_d;
    logic ct_rdy_q, ct_rdy_d, pt_rdy_q, pt_rdy_d, error_q, error_d;

    logic         key_load, key_rej, req_any, req_bad, req_ok, dec_bad, start, last;
    logic [31:0]  temp, oldest, new_word;
    logic [3:0]   kr;
    logic [5:0]   base;
    logic [127:0] rk, enc_next;
`ifdef AES_DECRYPT_EN
    logic [127:0] dec_next;
`endif

    // Request admission: key loads only while the engine is idle, one pending block at a time
    always_comb begin
`ifdef AES_DECRYPT_EN
        dec_bad = 1'b0;
`else
        dec_bad = ct_valid;
`endif
        key_load = (key_len != 2'b00) && !busy_q;
        key_rej  = (key_len != 2'b00) && busy_q;
        req_any  = pt_valid | ct_valid;
        req_bad  = (pt_valid & ct_valid) | dec_bad | (req_any & (pend_valid_q | busy_q))
                 | (req_any & !status_q & !exp_active_q & !key_load);
        req_ok   = req_any & !req_bad;
        start    = pend_valid_q & status_q & !busy_q & !key_load;
    end

    // Next key schedule word from a sliding window of the last Nk words (newest in [31:0])
    always_comb begin
        temp = win_q[31:0];
        if (kpos_q == 3'd0)
            temp = sub_word({win_q[23:0], win_q[31:24]}) ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && kpos_q == 3'd4)
            temp = sub_word(win_q[31:0]);
        case (nk_q)
            4'd4:    oldest = win_q[127:96];
            4'd6:    oldest = win_q[191:160];
            default: oldest = win_q[255:224];
        endcase
        new_word = oldest ^ temp;
    end

    // One cipher round; round keys are walked upward for encryption, downward for decryption
    always_comb begin
        if (start) kr = pend_dec_q ? nr_q : 4'd0;
        else       kr = dec_q ? nr_q - round_q : round_q;
        base = {kr, 2'b00};
        rk   = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
        last = (round_q == nr_q);
        enc_next = shift_rows(sub_bytes(state_q));
        if (!last) enc_next = mix_columns(enc_next);
        enc_next = enc_next ^ rk;
`ifdef AES_DECRYPT_EN
        dec_next = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk;
        if (!last) dec_next = inv_mix_columns(dec_next);
`endif
    end

    // Next-state for key expansion, pending slot and round engine
    always_comb begin
        state_d = state_q;  pend_data_d = pend_data_q;  ct_encr_d = ct_encr_q;  pt_decr_d = pt_decr_q;
        win_d = win_q;  exp_idx_d = exp_idx_q;  nk_d = nk_q;  nr_d = nr_q;  round_d = round_q;
        kpos_d = kpos_q;  rcon_d = rcon_q;  busy_d = busy_q;  dec_d = dec_q;
        pend_valid_d = pend_valid_q;  pend_dec_d = pend_dec_q;
        exp_active_d = exp_active_q;  status_d = status_q;
        ct_rdy_d = 1'b0;  pt_rdy_d = 1'b0;  error_d = req_bad | key_rej;

        if (key_load) begin
            case (key_len)
                2'b01:   begin nk_d = 4'd4; win_d = {128'h0, short_key[255:128]}; end
                2'b10:   begin nk_d = 4'd6; win_d = {64'h0, short_key[255:64]}; end
                default: begin nk_d = 4'd8; win_d = short_key; end
            endcase
            nr_d = nk_d + 4'd6;  exp_idx_d = {2'b00, nk_d};  kpos_d = 3'd0;  rcon_d = 8'h01;
            exp_active_d = 1'b1;  status_d = 1'b0;
        end else if (exp_active_q) begin
            win_d = {win_q[223:0], new_word};
            exp_idx_d = exp_idx_q + 6'd1;
            kpos_d = ({1'b0, kpos_q} == nk_q - 4'd1) ? 3'd0 : kpos_q + 3'd1;
            if (kpos_q == 3'd0) rcon_d = xt(rcon_q);
            if (exp_idx_q == {nr_q, 2'b00} + 6'd3) begin
                exp_active_d = 1'b0;
                status_d = 1'b1;
            end
        end

        if (start) begin
            busy_d = 1'b1;  dec_d = pend_dec_q;  state_d = pend_data_q ^ rk;
            round_d = 4'd1;  pend_valid_d = 1'b0;
        end else if (busy_q) begin
            round_d = round_q + 4'd1;
            if (last) busy_d = 1'b0;
`ifdef AES_DECRYPT_EN
            if (dec_q) begin
                state_d = dec_next;
                if (last) begin pt_decr_d = dec_next; pt_rdy_d = 1'b1; end
            end else
`endif
            begin
                state_d = enc_next;
                if (last) begin ct_encr_d = enc_next; ct_rdy_d = 1'b1; end
            end
        end

        if (req_ok) begin
            pend_valid_d = 1'b1;  pend_dec_d = ct_valid;
            pend_data_d = ct_valid ? ct_decr : pt_encr;
        end
    end

    // Control and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;  pend_data_q <= '0;  ct_encr_q <= '0;  pt_decr_q <= '0;
            win_q <= '0;  exp_idx_q <= '0;  nk_q <= 4'd4;  nr_q <= 4'd10;  round_q <= '0;
            kpos_q <= '0;  rcon_q <= 8'h01;  busy_q <= 1'b0;  dec_q <= 1'b0;
            pend_valid_q <= 1'b0;  pend_dec_q <= 1'b0;  exp_active_q <= 1'b0;  status_q <= 1'b0;
            ct_rdy_q <= 1'b0;  pt_rdy_q <= 1'b0;  error_q <= 1'b0;
        end else begin
            state_q <= state_d;  pend_data_q <= pend_data_d;  ct_encr_q <= ct_encr_d;  pt_decr_q <= pt_decr_d;
            win_q <= win_d;  exp_idx_q <= exp_idx_d;  nk_q <= nk_d;  nr_q <= nr_d;  round_q <= round_d;
            kpos_q <= kpos_d;  rcon_q <= rcon_d;  busy_q <= busy_d;  dec_q <= dec_d;
            pend_valid_q <= pend_valid_d;  pend_dec_q <= pend_dec_d;
            exp_active_q <= exp_active_d;  status_q <= status_d;
            ct_rdy_q <= ct_rdy_d;  pt_rdy_q <= pt_rdy_d;  error_q <= error_d;
        end
    end

    // Round key store; validity is tracked by status_q, so the words need no reset
    always_ff @(posedge clk) begin
        if (key_load) begin
            for (int j = 0; j < 8; j++) w_q[j] <= short_key[255-32*j -: 32];
        end else if (exp_active_q) begin
            w_q[exp_idx_q] <= new_word;
        end
    end

    assign ct_rdy         = ct_rdy_q;
    assign ct_encr        = ct_encr_q;
    assign pt_rdy         = pt_rdy_q;
    assign pt_decr        = pt_decr_q;
    assign key_exp_status = status_q;
    assign error          = error_q;

endmodule

// File: tb/tb_aes.sv
// tb/tb_aes.sv - directed self-checking bench for aes
module tb_aes;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         pt_valid = 1'b0, ct_valid = 1'b0;
    logic [127:0] pt_encr = '0, ct_decr = '0;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] short_key = '0;
    logic         ct_rdy, pt_rdy, key_exp_status, error;
    logic [127:0] ct_encr, pt_decr;

    int n_checks = 0;
    int n_err = 0;
    logic both_seen = 1'b0;

    localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;

    aes dut (
        .clk(clk), .reset(reset),
        .pt_valid(pt_valid), .pt_encr(pt_encr), .ct_rdy(ct_rdy), .ct_encr(ct_encr),
        .ct_valid(ct_valid), .ct_decr(ct_decr), .pt_rdy(pt_rdy), .pt_decr(pt_decr),
        .key_len(key_len), .short_key(short_key),
        .key_exp_status(key_exp_status), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ct_rdy && pt_rdy) both_seen = 1'b1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_status(output int cyc);
        cyc = 0;
        while (!key_exp_status && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_rdy(input logic want_pt, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(want_pt ? pt_rdy : ct_rdy) && cyc < 100);
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (ct_rdy || pt_rdy) pulses++;
        end
    endtask

    // Key load and encrypt request in the same cycle; checks schedule length and ciphertext
    task automatic run_enc(input string tag, input logic [1:0] kl, input logic [255:0] key,
                           input logic [127:0] pt, input logic [127:0] exp_ct, input int words);
        int cyc;
        @(negedge clk);
        key_len = kl; short_key = key; pt_valid = 1'b1; pt_encr = pt;
        @(negedge clk);
        key_len = 2'b00; pt_valid = 1'b0;
        check({tag, "_status_drop"}, 128'(key_exp_status), 128'd0);
        check({tag, "_no_error"}, 128'(error), 128'd0);
        wait_status(cyc);
        check({tag, "_exp_cycles"}, 128'(cyc), 128'(words));
        wait_rdy(1'b0, cyc);
        check({tag, "_ct_rdy"}, 128'(ct_rdy), 128'd1);
        check({tag, "_ct"}, ct_encr, exp_ct);
        check({tag, "_pt_rdy_quiet"}, 128'(pt_rdy), 128'd0);
        @(negedge clk);
        check({tag, "_ct_rdy_pulse"}, 128'(ct_rdy), 128'd0);
        check({tag, "_ct_held"}, ct_encr, exp_ct);
    endtask

    task automatic send_pt(input logic [127:0] pt);
        @(negedge clk);
        pt_valid = 1'b1; pt_encr = pt;
        @(negedge clk);
        pt_valid = 1'b0;
    endtask

    initial begin
        int cyc, pulses;
        repeat (2) @(negedge clk);
        check("rst_ct_encr", ct_encr, 128'd0);
        check("rst_pt_decr", pt_decr, 128'd0);
        check("rst_ct_rdy", 128'(ct_rdy), 128'd0);
        check("rst_pt_rdy", 128'(pt_rdy), 128'd0);
        check("rst_error", 128'(error), 128'd0);
        check("rst_status", 128'(key_exp_status), 128'd0);
        reset = 1'b1;

        // request with no key and no expansion running
        send_pt(PT0);
        check("nokey_error", 128'(error), 128'd1);
        @(negedge clk);
        check("nokey_error_pulse", 128'(error), 128'd0);

        run_enc("aes128", 2'b01, K128, PT0, CT128, 40);
        run_enc("aes192", 2'b10, K192, PT0, CT192, 46);
        run_enc("aes256", 2'b11, K256, PT0, CT256, 52);

`ifdef AES_DECRYPT_EN
        @(negedge clk);
        ct_valid = 1'b1; ct_decr = CT256;
        @(negedge clk);
        ct_valid = 1'b0;
        wait_rdy(1'b1, cyc);
        check("dec_pt_rdy", 128'(pt_rdy), 128'd1);
        check("dec_pt", pt_decr, PT0);
        check("dec_ct_rdy_quiet", 128'(ct_rdy), 128'd0);
`else
        @(negedge clk);
        ct_valid = 1'b1; ct_decr = CT256;
        @(negedge clk);
        ct_valid = 1'b0;
        check("nodec_error", 128'(error), 128'd1);
        count_pulses(20, pulses);
        check("nodec_no_pulse", 128'(pulses), 128'd0);
        check("nodec_pt_decr", pt_decr, 128'd0);
`endif

        run_enc("fips_b", 2'b01, KB, PTB, CTB, 40);

        // request while the engine is busy
        send_pt(PTB);
        repeat (3) @(negedge clk);
        pt_valid = 1'b1; pt_encr = PT0;
        @(negedge clk);
        pt_valid = 1'b0;
        check("busy_error", 128'(error), 128'd1);
        @(negedge clk);
        check("busy_error_pulse", 128'(error), 128'd0);
        wait_rdy(1'b0, cyc);
        check("busy_ct_rdy", 128'(ct_rdy), 128'd1);
        check("busy_ct", ct_encr, CTB);

        // key load while busy is ignored
        send_pt(PTB);
        repeat (2) @(negedge clk);
        key_len = 2'b01; short_key = K128;
        @(negedge clk);
        key_len = 2'b00;
        check("keybusy_error", 128'(error), 128'd1);
        wait_rdy(1'b0, cyc);
        check("keybusy_ct", ct_encr, CTB);
        check("keybusy_status", 128'(key_exp_status), 128'd1);
        send_pt(PTB);
        wait_rdy(1'b0, cyc);
        check("keybusy_key_kept", ct_encr, CTB);

        // both requests at once are dropped
        @(negedge clk);
        pt_valid = 1'b1; ct_valid = 1'b1; pt_encr = PT0; ct_decr = CT256;
        @(negedge clk);
        pt_valid = 1'b0; ct_valid = 1'b0;
        check("both_error", 128'(error), 128'd1);
        count_pulses(20, pulses);
        check("both_no_result", 128'(pulses), 128'd0);
        check("both_ct_unchanged", ct_encr, CTB);

        // reset in the middle of an encryption
        send_pt(PT0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_ct_encr", ct_encr, 128'd0);
        check("midrst_status", 128'(key_exp_status), 128'd0);
        check("midrst_ct_rdy", 128'(ct_rdy), 128'd0);
        check("midrst_error", 128'(error), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        count_pulses(20, pulses);
        check("midrst_no_result", 128'(pulses), 128'd0);
        send_pt(PT0);
        check("midrst_schedule_gone", 128'(error), 128'd1);

        check("rdy_exclusive", 128'(both_seen), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
